// File: rtl/cms_trace_fifo.sv
// cms_trace_fifo: first-word-fall-through trace buffer between the monitor and
// the DMA engine. Optionally drops beats when full instead of stalling, counts
// the losses and keeps packet boundaries intact across dropped tlast beats.
module cms_trace_fifo #(
    parameter int AXI_DATA_WIDTH = 96,
    parameter int DEPTH          = 16,
    parameter bit DROP_WHEN_FULL = 1'b1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          S_AXIS_tvalid,
    output logic                          S_AXIS_tready,
    input  logic [AXI_DATA_WIDTH-1:0]     S_AXIS_tdata,
    input  logic                          S_AXIS_tlast,
    output logic                          M_AXIS_tvalid,
    input  logic                          M_AXIS_tready,
    output logic [AXI_DATA_WIDTH-1:0]     M_AXIS_tdata,
    output logic                          M_AXIS_tlast,
    output logic [$clog2(DEPTH):0]        occupancy,
    output logic [31:0]                   drop_count,
    output logic                          overflow,
    input  logic                          clear_stats
);

    localparam int AW = $clog2(DEPTH);

    // Each entry holds {tlast, tdata}
    logic [AXI_DATA_WIDTH:0] mem [DEPTH];
    logic [AW:0]             wr_ptr;
    logic [AW:0]             rd_ptr;
    logic                    last_pending;
    logic                    full;
    logic                    empty;
    logic                    push;
    logic                    pop;
    logic                    drop;

    // Extra wrap bit distinguishes full from empty when the indices match
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty = (wr_ptr == rd_ptr);

    // All decisions use the state sampled at the start of the cycle, so a pop
    // in a full cycle never frees room for the incoming beat
    assign push = S_AXIS_tvalid && !full;
    assign pop  = !empty && M_AXIS_tready;
    assign drop = DROP_WHEN_FULL && S_AXIS_tvalid && full;

    assign S_AXIS_tready = !full || DROP_WHEN_FULL;
    assign M_AXIS_tvalid = !empty;
    assign {M_AXIS_tlast, M_AXIS_tdata} = mem[rd_ptr[AW-1:0]];
    assign occupancy = wr_ptr - rd_ptr;

    // Data storage, not reset; a boundary owed by a dropped tlast beat is
    // folded into the next stored beat
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[AW-1:0]] <= {S_AXIS_tlast | last_pending, S_AXIS_tdata};
        end
    end

    // Read/write pointer advance
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    // Remember a dropped packet boundary until the next beat is stored
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_pending <= 1'b0;
        end else if (drop && S_AXIS_tlast) begin
            last_pending <= 1'b1;
        end else if (push) begin
            last_pending <= 1'b0;
        end
    end

    // Drop statistics; a drop coinciding with a clear is counted after the clear
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_count <= '0;
            overflow   <= 1'b0;
        end else if (clear_stats) begin
            drop_count <= drop ? 32'd1 : 32'd0;
            overflow   <= drop;
        end else if (drop) begin
            if (drop_count != '1) drop_count <= drop_count + 32'd1;
            overflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_cms_trace_fifo.sv
// Bench for cms_trace_fifo: one back-pressure instance and one drop-mode
// instance driven with identical stimulus, each compared every cycle against a
// queue-based reference model, plus a vector table and directed sequences.
module tb_cms_trace_fifo;

    logic        clk;
    logic        rst_n;
    logic        sv;
    logic [95:0] sd;
    logic        sl;
    logic        mr;
    logic        clr;

    logic [1:0]  s_tready;
    logic [1:0]  m_tvalid;
    logic [1:0]  m_tlast;
    logic [1:0]  ovf;
    logic [95:0] m_tdata [2];
    logic [4:0]  occ     [2];
    logic [31:0] dcnt    [2];

    int checks   = 0;
    int failures = 0;

    // Reference model state per instance (0: back-pressure, 1: drop mode)
    logic [96:0] mq  [2][$];
    logic [31:0] mdc [2];
    logic        mov [2];
    logic        mlp [2];

    cms_trace_fifo #(.AXI_DATA_WIDTH(96), .DEPTH(16), .DROP_WHEN_FULL(1'b0)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .S_AXIS_tvalid(sv), .S_AXIS_tready(s_tready[0]), .S_AXIS_tdata(sd), .S_AXIS_tlast(sl),
        .M_AXIS_tvalid(m_tvalid[0]), .M_AXIS_tready(mr), .M_AXIS_tdata(m_tdata[0]),
        .M_AXIS_tlast(m_tlast[0]), .occupancy(occ[0]), .drop_count(dcnt[0]),
        .overflow(ovf[0]), .clear_stats(clr)
    );

    cms_trace_fifo #(.AXI_DATA_WIDTH(96), .DEPTH(16), .DROP_WHEN_FULL(1'b1)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .S_AXIS_tvalid(sv), .S_AXIS_tready(s_tready[1]), .S_AXIS_tdata(sd), .S_AXIS_tlast(sl),
        .M_AXIS_tvalid(m_tvalid[1]), .M_AXIS_tready(mr), .M_AXIS_tdata(m_tdata[1]),
        .M_AXIS_tlast(m_tlast[1]), .occupancy(occ[1]), .drop_count(dcnt[1]),
        .overflow(ovf[1]), .clear_stats(clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        sv;
        logic [95:0] sd;
        logic        sl;
        logic        mr;
        logic [4:0]  occ;
        logic        mv;
        logic [95:0] md;
        logic        ml;
    } vec_t;

    vec_t tbl [5];

    function automatic logic [95:0] mk(input logic [63:0] pc, input logic [31:0] instr);
        return {instr, pc};
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mq[m].delete();
            mdc[m] = '0;
            mov[m] = 1'b0;
            mlp[m] = 1'b0;
        end
    endtask

    task automatic model_check();
        for (int m = 0; m < 2; m++) begin
            int sz = mq[m].size();
            chk($sformatf("m%0d.s_tready", m), s_tready[m], (sz < 16) || (m == 1));
            chk($sformatf("m%0d.m_tvalid", m), m_tvalid[m], sz > 0);
            chk($sformatf("m%0d.occupancy", m), occ[m], sz);
            chk($sformatf("m%0d.drop_count", m), dcnt[m], mdc[m]);
            chk($sformatf("m%0d.overflow", m), ovf[m], mov[m]);
            if (sz > 0) begin
                logic [96:0] hd = mq[m][0];
                chk($sformatf("m%0d.m_tdata", m), m_tdata[m], hd[95:0]);
                chk($sformatf("m%0d.m_tlast", m), m_tlast[m], hd[96]);
            end
        end
    endtask

    task automatic model_update();
        for (int m = 0; m < 2; m++) begin
            int sz = mq[m].size();
            bit is_full = (sz == 16);
            bit do_push = sv && !is_full;
            bit do_pop  = (sz > 0) && mr;
            bit do_drop = (m == 1) && sv && is_full;
            if (do_pop) void'(mq[m].pop_front());
            if (do_push) begin
                mq[m].push_back({sl | mlp[m], sd});
                mlp[m] = 1'b0;
            end
            if (do_drop && sl) mlp[m] = 1'b1;
            if (clr) begin
                mdc[m] = do_drop ? 32'd1 : 32'd0;
                mov[m] = do_drop;
            end else if (do_drop) begin
                if (mdc[m] != 32'hFFFF_FFFF) mdc[m] = mdc[m] + 32'd1;
                mov[m] = 1'b1;
            end
        end
    endtask

    // Called just after a falling edge with inputs already applied
    task automatic cycle();
        #1;
        model_check();
        model_update();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        sv = 1'b0; sd = '0; sl = 1'b0; mr = 1'b0; clr = 1'b0;
    endtask

    task automatic fill16(input logic [63:0] base);
        for (int i = 0; i < 16; i++) begin
            sv = 1'b1; sd = mk(base + 64'(4 * i), 32'(i)); sl = 1'b0; mr = 1'b0;
            cycle();
        end
        sv = 1'b0;
    endtask

    task automatic drain(input int n);
        sv = 1'b0; mr = 1'b1;
        for (int i = 0; i < n; i++) cycle();
        mr = 1'b0;
    endtask

    initial begin
        idle_inputs();
        rst_n = 1'b0;
        model_reset();

        tbl[0] = '{sv: 1'b0, sd: '0, sl: 1'b0, mr: 1'b0, occ: 5'd0, mv: 1'b0, md: '0, ml: 1'b0};
        tbl[1] = '{sv: 1'b1, sd: mk(64'h0000_0000_0000_0A00, 32'h1111_0001), sl: 1'b0, mr: 1'b0,
                   occ: 5'd0, mv: 1'b0, md: '0, ml: 1'b0};
        tbl[2] = '{sv: 1'b1, sd: mk(64'h0000_0000_0000_0B00, 32'h2222_0002), sl: 1'b1, mr: 1'b1,
                   occ: 5'd1, mv: 1'b1, md: mk(64'h0000_0000_0000_0A00, 32'h1111_0001), ml: 1'b0};
        tbl[3] = '{sv: 1'b0, sd: '0, sl: 1'b0, mr: 1'b1,
                   occ: 5'd1, mv: 1'b1, md: mk(64'h0000_0000_0000_0B00, 32'h2222_0002), ml: 1'b1};
        tbl[4] = '{sv: 1'b0, sd: '0, sl: 1'b0, mr: 1'b0, occ: 5'd0, mv: 1'b0, md: '0, ml: 1'b0};

        // Reset state
        #12;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("rst.m%0d.s_tready", m), s_tready[m], 1'b1);
            chk($sformatf("rst.m%0d.m_tvalid", m), m_tvalid[m], 1'b0);
            chk($sformatf("rst.m%0d.occupancy", m), occ[m], 5'd0);
            chk($sformatf("rst.m%0d.drop_count", m), dcnt[m], 32'd0);
            chk($sformatf("rst.m%0d.overflow", m), ovf[m], 1'b0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: first-word-fall-through latency and back-to-back pop/push
        for (int v = 0; v < 5; v++) begin
            sv = tbl[v].sv; sd = tbl[v].sd; sl = tbl[v].sl; mr = tbl[v].mr;
            #1;
            for (int m = 0; m < 2; m++) begin
                chk($sformatf("tbl%0d.m%0d.occupancy", v, m), occ[m], tbl[v].occ);
                chk($sformatf("tbl%0d.m%0d.m_tvalid", v, m), m_tvalid[m], tbl[v].mv);
                if (tbl[v].mv) begin
                    chk($sformatf("tbl%0d.m%0d.m_tdata", v, m), m_tdata[m], tbl[v].md);
                    chk($sformatf("tbl%0d.m%0d.m_tlast", v, m), m_tlast[m], tbl[v].ml);
                end
            end
            cycle();
        end
        idle_inputs();

        // Fill to DEPTH with the sink stalled
        fill16(64'h0000_0000_8000_0000);
        chk("fill.m0.s_tready", s_tready[0], 1'b0);
        chk("fill.m1.s_tready", s_tready[1], 1'b1);
        chk("fill.m0.occupancy", occ[0], 5'd16);
        chk("fill.m1.occupancy", occ[1], 5'd16);

        // Five beats into a full FIFO, third one closes a packet
        for (int k = 0; k < 5; k++) begin
            sv = 1'b1; sd = mk(64'h0000_0000_9000_0000 + 64'(k), 32'hDEAD_0000); sl = (k == 2); mr = 1'b0;
            cycle();
        end
        chk("drop5.m1.drop_count", dcnt[1], 32'd5);
        chk("drop5.m1.overflow", ovf[1], 1'b1);
        chk("drop5.m0.drop_count", dcnt[0], 32'd0);
        chk("drop5.m0.overflow", ovf[0], 1'b0);

        // Pop and offer a beat in the same full cycle
        sv = 1'b1; sd = mk(64'h0000_0000_9000_00FF, 32'hDEAD_00FF); sl = 1'b0; mr = 1'b1;
        #1;
        chk("fullpop.m0.s_tready_held_low", s_tready[0], 1'b0);
        cycle();
        chk("fullpop.m1.occupancy", occ[1], 5'd15);
        chk("fullpop.m1.drop_count", dcnt[1], 32'd6);
        chk("fullpop.m0.occupancy", occ[0], 5'd15);
        chk("fullpop.m0.s_tready_back", s_tready[0], 1'b1);

        // Next stored beat inherits the boundary of the dropped tlast beat
        sv = 1'b1; sd = mk(64'h0000_0000_8000_0100, 32'h0000_0100); sl = 1'b0; mr = 1'b0;
        cycle();
        chk("refill.m1.occupancy", occ[1], 5'd16);
        sv = 1'b0; mr = 1'b1;
        for (int i = 0; i < 16; i++) begin
            #1;
            if (i < 15) begin
                chk("drain.m0.order", m_tdata[0][63:0], 64'h8000_0000 + 64'(4 * (i + 1)));
            end else begin
                chk("drain.m1.forced_tlast", m_tlast[1], 1'b1);
                chk("drain.m0.plain_tlast", m_tlast[0], 1'b0);
                chk("drain.m1.last_pc", m_tdata[1][63:0], 64'h8000_0100);
            end
            cycle();
        end
        mr = 1'b0;
        chk("drain.m0.occupancy", occ[0], 5'd0);
        chk("drain.m1.occupancy", occ[1], 5'd0);

        // Statistics clear, with and without a coincident drop
        fill16(64'h0000_0000_A000_0000);
        sv = 1'b1; sd = mk(64'h0000_0000_A000_0FFF, 32'h0); sl = 1'b0;
        cycle();
        chk("clr.pre.m1.drop_count", dcnt[1], 32'd7);
        sv = 1'b0; clr = 1'b1;
        cycle();
        chk("clr.idle.m1.drop_count", dcnt[1], 32'd0);
        chk("clr.idle.m1.overflow", ovf[1], 1'b0);
        sv = 1'b1;
        cycle();
        chk("clr.drop.m1.drop_count", dcnt[1], 32'd1);
        chk("clr.drop.m1.overflow", ovf[1], 1'b1);
        clr = 1'b0;
        drain(16);

        // Streaming at full rate with tlast every tenth beat
        for (int i = 0; i < 100; i++) begin
            sv = 1'b1; sd = mk(64'h1000 + 64'(4 * i), 32'(i * 7)); sl = ((i % 10) == 9); mr = 1'b1;
            #1;
            chk("stream.m0.occ_le1", occ[0] <= 5'd1, 1'b1);
            chk("stream.m1.occ_le1", occ[1] <= 5'd1, 1'b1);
            cycle();
        end
        drain(3);

        // Randomized traffic alternating between light and heavy back-pressure
        for (int i = 0; i < 2000; i++) begin
            int mr_pct = (((i / 250) % 2) == 1) ? 20 : 85;
            sv  = ($urandom_range(0, 99) < 75);
            sd  = {$urandom(), $urandom(), $urandom()};
            sl  = ($urandom_range(0, 9) == 0);
            mr  = ($urandom_range(0, 99) < mr_pct);
            clr = ($urandom_range(0, 59) == 0);
            cycle();
        end
        idle_inputs();
        drain(20);

        // Asynchronous reset with nine beats buffered
        for (int i = 0; i < 9; i++) begin
            sv = 1'b1; sd = mk(64'h0000_0000_C000_0000 + 64'(i), 32'hC0DE_0000); sl = 1'b0; mr = 1'b0;
            cycle();
        end
        sv = 1'b0;
        chk("prereset.m0.occupancy", occ[0], 5'd9);
        chk("prereset.m1.occupancy", occ[1], 5'd9);
        #2;
        rst_n = 1'b0;
        #1;
        for (int m = 0; m < 2; m++) begin
            chk($sformatf("areset.m%0d.s_tready", m), s_tready[m], 1'b1);
            chk($sformatf("areset.m%0d.m_tvalid", m), m_tvalid[m], 1'b0);
            chk($sformatf("areset.m%0d.occupancy", m), occ[m], 5'd0);
            chk($sformatf("areset.m%0d.drop_count", m), dcnt[m], 32'd0);
            chk($sformatf("areset.m%0d.overflow", m), ovf[m], 1'b0);
        end
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        sv = 1'b1; sd = mk(64'h0000_0000_D000_0000, 32'hFEED_BEEF); sl = 1'b1; mr = 1'b0;
        cycle();
        sv = 1'b0;
        #1;
        chk("postreset.m0.m_tdata", m_tdata[0], mk(64'h0000_0000_D000_0000, 32'hFEED_BEEF));
        chk("postreset.m1.m_tdata", m_tdata[1], mk(64'h0000_0000_D000_0000, 32'hFEED_BEEF));
        chk("postreset.m1.m_tlast", m_tlast[1], 1'b1);
        cycle();
        drain(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cms_trace_fifo.md
# cms_trace_fifo

Buffering stage directly downstream of `continuous_monitoring_system`. It accepts trace beats on an AXI-Stream slave: 96-bit `{instr, pc}` packets with `tlast` every `tlast_interval` beats. It re-presents them on an AXI-Stream master toward the DMA engine. It absorbs DMA back-pressure bursts and, when configured, drops beats instead of stalling the monitor, keeping statistics on what was lost.

## Interface
Parameters:
- `AXI_DATA_WIDTH`, 96: beat width (64-bit pc plus 32-bit instr).
- `DEPTH`, 16: number of entries; a power of two, at least 2.
- `DROP_WHEN_FULL`, 1:
  - 1: drop beats when full and never deassert `S_AXIS_tready`.
  - 0: apply back-pressure when full.

Ports (`AW = $clog2(DEPTH)`):
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `S_AXIS_tvalid` in 1: upstream beat valid.
- `S_AXIS_tready` out 1: this block can accept (or drop) the beat.
- `S_AXIS_tdata` in `AXI_DATA_WIDTH`: upstream beat.
- `S_AXIS_tlast` in 1: upstream packet boundary.
- `M_AXIS_tvalid` out 1: head entry valid.
- `M_AXIS_tready` in 1: downstream accepts the head.
- `M_AXIS_tdata` out `AXI_DATA_WIDTH`: head entry data.
- `M_AXIS_tlast` out 1: head entry boundary flag.
- `occupancy` out `AW+1`: number of stored entries, 0..DEPTH.
- `drop_count` out 32: number of dropped beats; saturates at 0xFFFFFFFF.
- `overflow` out 1: sticky flag, set by any drop.
- `clear_stats` in 1: synchronous clear of `drop_count` and `overflow`.

## Operation
- Storage: `DEPTH` entries of `{tlast, tdata}`, plus read/write pointers with an extra wrap bit.
  - full = pointers equal except the wrap bit; empty = pointers equal.
  - Pointers wrap modulo `2*DEPTH`.
- The data array is not reset. `M_AXIS_tdata` and `M_AXIS_tlast` are don't-care while `M_AXIS_tvalid`=0.
- Outputs:
  - `S_AXIS_tready` = !full || `DROP_WHEN_FULL`. It is a function of registered state only, with no combinational path from `M_AXIS_tready`.
  - `M_AXIS_tvalid` = !empty.
  - `M_AXIS_tdata` / `M_AXIS_tlast` = the entry at the read pointer (first-word-fall-through).
- Push: `S_AXIS_tvalid` && !full (full as sampled at the start of the cycle). Stores the beat and increments the write pointer.
- Pop: `M_AXIS_tvalid` && `M_AXIS_tready`. Increments the read pointer.
- Drop (only when `DROP_WHEN_FULL`=1): `S_AXIS_tvalid` && full. The beat is discarded even if a pop occurs in the same cycle. On a drop:
  - `drop_count` increments, saturating;
  - `overflow` is set to 1;
  - if the dropped beat has `tlast`=1, `last_pending` is set to 1.
- Boundary preservation: while `last_pending`=1, the next pushed beat is stored with tlast forced to 1 and `last_pending` clears. This guarantees the DMA transfer still terminates.
- `occupancy`: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop.
- `clear_stats`:
  - In a cycle with no drop, `drop_count` becomes 0 and `overflow` becomes 0.
  - If a drop occurs in the same cycle, `drop_count` becomes 1 and `overflow` becomes 1.
  - Pointers and `last_pending` are unaffected.
- Reset (asserted at any time, including mid-stream):
  - pointers = 0, `occupancy`=0, `M_AXIS_tvalid`=0;
  - `S_AXIS_tready`=1, `drop_count`=0, `overflow`=0, `last_pending`=0.
  - Buffered beats are lost. No partial state survives reset.

## Timing
- Latency: a beat pushed at rising edge N appears with `M_AXIS_tvalid`=1 immediately after edge N, and can be popped at edge N+1.
- Full throughput: one push and one pop per cycle sustained at any occupancy.
- Empty FIFO: a push and a pop cannot coincide, because `M_AXIS_tvalid`=0 during the push cycle (no bypass).
- Full FIFO with `DROP_WHEN_FULL`=0:
  - `S_AXIS_tready`=0 for the entire cycle, even if a pop occurs in that cycle;
  - it returns to 1 the cycle after occupancy drops below `DEPTH`.
- Statistics: `drop_count`, `overflow` and `occupancy` are registered and update on the edge that performs the event.
- The AXI-Stream rule is honoured: once `M_AXIS_tvalid`=1, the head data remains stable until popped.

## Test plan
- Fill and drain, `DEPTH`=16, `DROP_WHEN_FULL`=0, `M_AXIS_tready`=0:
  - push pc 0x80000000, 0x80000004, …;
  - `S_AXIS_tready` falls after the 16th push and `occupancy`=16;
  - then hold `M_AXIS_tready`=1: 16 beats emerge in order, and `occupancy` returns to 0.
- Streaming: `tvalid`=1 and `tready`=1 continuously for 100 beats with `tlast` every 10:
  - output order and `tlast` positions match the input exactly;
  - `occupancy` is never above 1.
- Drop mode: full FIFO, `M_AXIS_tready`=0, push 5 more beats, with the 3rd carrying `tlast`=1:
  - `drop_count`=5 and `overflow`=1;
  - after one pop and one push, the newly stored beat has `tlast`=1.
- Simultaneous full pop and push, `DROP_WHEN_FULL`=1: the incoming beat is dropped, `occupancy` goes 16 to 15, and `drop_count` increments.
- Clear: `clear_stats` pulsed while `drop_count`=7 with no drop gives 0 and `overflow`=0. Pulsed coincident with a drop, it gives `drop_count`=1.
- Reset: assert `rst_n`=0 asynchronously mid-stream with `occupancy`=9. All outputs take their reset values before the next edge, and the first beat after release emerges unchanged.
